board_vram_writer: RTL and testbench
====================================

Name: board_vram_writer

Overview:
- Write-side client of the 14x14x6-bit board VRAM; the VGA renderer is the read-side client.
- Accepts piece-placement and board-clear commands over a valid/ready handshake.
- Converts each command into a sequence of single-cell VRAM writes at address y*14+x.
- Rejects placements that fall off the board; optionally rejects placements that overlap occupied cells.

Parameters:
- BOARD_W, 14, board width and height in cells.
- CELL_W, 6, cell data width (player/colour flag bits).
- ADDR_W, 8, VRAM address width.

Ports:
- clk  in  1  system clock; all logic rises on posedge clk.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_op  in  1  0 = place piece, 1 = clear board.
- cmd_shape  in  25  5x5 piece mask; bit i covers cell dx=i%5, dy=i/5.
- cmd_x  in  4  piece origin column, 0..15.
- cmd_y  in  4  piece origin row, 0..15.
- cmd_cell  in  6  value written to each covered cell.
- vram_wraddress  out  8  VRAM write address.
- vram_data  out  6  VRAM write data.
- vram_wren  out  1  VRAM write enable.
- vram_rdaddress  out  8  VRAM read address (collision check only).
- vram_q  in  6  VRAM read data, valid 1 cycle after the address is presented.
- done  out  1  one-cycle pulse when a command completes.
- err  out  2  status of the last command; bit0 = off-board, bit1 = collision. Held until the next command is accepted.

Behaviour:
- Reset values: cmd_ready=1, vram_wren=0, vram_wraddress=0, vram_data=0, vram_rdaddress=0, done=0, err=0, state=IDLE.
- Reset asserted mid-command aborts the command at once; no further writes are issued.
- Accept rule: a command is accepted on a cycle with cmd_valid & cmd_ready. cmd_ready=1 only in IDLE.
- On accept, cmd_* are latched and err is cleared to 0.
- The off-board flag is computed combinationally at accept and latched:
  - Flag = OR over i of (shape[i] & (x+dx>=14 | y+dy>=14)).
  - Arithmetic is 5 bits wide, so x+dx can reach 19 without wraparound.
- States:
  - IDLE:
    - accept with op=1 -> CLEAR.
    - accept with op=0 and off-board flag -> DONE, err[0]=1, no writes.
    - accept with op=0 otherwise -> CHECK if COLLISION_CHECK_EN is defined, else PLACE.
  - CLEAR:
    - Counter 0..195; each cycle wren=1, addr=counter, data=0.
    - After address 195 -> DONE. Total 196 write cycles.
  - PLACE:
    - Index i runs 0..24, one per cycle (25 cycles regardless of mask).
    - wren=shape[i], addr=(y+dy)*14+(x+dx), data=cmd_cell.
    - After i=24 -> DONE.
  - CHECK: see Optional Feature.
  - DONE: done=1 for exactly one cycle, then -> IDLE; cmd_ready returns to 1 on the following cycle.
- Address arithmetic: row*14 implemented as row*8+row*4+row*2 (no multiplier). Result is at most 195 and fits in 8 bits.
- Command latency from accept to done pulse:
  - place: 26 cycles.
  - clear: 197 cycles.
  - rejected: 1 cycle.
- Writes overwrite existing cell contents unconditionally when no check is performed.
- cmd_valid held high while busy is ignored; no queuing.
- Shape of all zeros: 25 PLACE cycles with no writes; done with err=0.

Optional Feature:
- Macro: BOARD_VRAM_WRITER_COLLISION_CHECK_EN.
- Defined:
  - CHECK state sweeps i=0..24, driving vram_rdaddress for each in-bounds set bit.
  - A 1-cycle delayed valid tag qualifies vram_q; any nonzero qualified vram_q sets a sticky collision flag.
  - CHECK lasts 26 cycles (25 reads plus 1 drain).
  - Collision flag set -> DONE with err[1]=1 and no writes. Clear -> PLACE.
  - Place latency becomes 52 cycles.
- Undefined:
  - No CHECK state; vram_rdaddress tied to 0 and vram_q ignored.
  - err[1] is always 0.

Test Plan:
- Reset, then clear command -> exactly 196 writes, addresses 0..195 ascending, data 0; done on cycle 197; err=00.
- Place shape=25'h0000007 (3-cell bar), x=2, y=3, cell=6'b100000 -> writes at addresses 44, 45, 46 with data 6'h20; done 26 cycles after accept; err=00.
- Place shape bit 4 set, x=10 (column 14) -> no wren, done next cycle, err=01. Repeat with x=9 -> write at y*14+13.
- With macro defined, preload address 45 nonzero, place same bar as test 2 -> no writes, err=10, done at cycle 27. With macro undefined -> writes proceed, err=00.
- Assert rst_n low mid-CLEAR (counter=50) -> wren=0 immediately, cmd_ready=1 after release, done never pulses for the aborted command.
- cmd_valid held high continuously with two commands -> second command accepted only on the cycle after done; no overlap of write sequences.

Source files
------------

// File: rtl/board_vram_writer.sv
// Board VRAM write client: turns place/clear commands into single-cell writes.
// Optional overlap rejection via BOARD_VRAM_WRITER_COLLISION_CHECK_EN.
module board_vram_writer #(
  parameter int BOARD_W = 14,
  parameter int CELL_W  = 6,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [24:0]       cmd_shape,
  input  logic [3:0]        cmd_x,
  input  logic [3:0]        cmd_y,
  input  logic [CELL_W-1:0] cmd_cell,
  output logic [ADDR_W-1:0] vram_wraddress,
  output logic [CELL_W-1:0] vram_data,
  output logic              vram_wren,
  output logic [ADDR_W-1:0] vram_rdaddress,
  input  logic [CELL_W-1:0] vram_q,
  output logic              done,
  output logic [1:0]        err
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CHECK,
    PLACE,
    DONE
  } state_t;

  localparam int NCELL = BOARD_W * BOARD_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELL - 1);
  localparam logic [4:0] LAST_IDX = 5'd24;
  localparam logic [4:0] BW5 = 5'(BOARD_W);

  state_t            state;
  logic [24:0]       shape_q;
  logic [3:0]        x_q;
  logic [3:0]        y_q;
  logic [CELL_W-1:0] cell_q;
  logic [4:0]        idx;
  logic [2:0]        dx;
  logic [2:0]        dy;
  logic [ADDR_W-1:0] clr_cnt;

  logic              off_board;
  logic [4:0]        cur_row;
  logic [4:0]        cur_col;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_bit;
  logic [2:0]        dx_nx;
  logic [2:0]        dy_nx;

  // row*14 as row*8 + row*4 + row*2
  function automatic logic [ADDR_W-1:0] cell_addr(
    input logic [4:0] row,
    input logic [4:0] col
  );
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 3) + (r << 2) + (r << 1) + ADDR_W'(col);
  endfunction

  always_comb begin
    off_board = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (cmd_shape[i] &&
          ((({1'b0, cmd_x} + 5'(i % 5)) >= BW5) ||
           (({1'b0, cmd_y} + 5'(i / 5)) >= BW5)))
        off_board = 1'b1;
    end
  end

  assign cur_row  = {1'b0, y_q} + {2'b00, dy};
  assign cur_col  = {1'b0, x_q} + {2'b00, dx};
  assign cur_addr = cell_addr(cur_row, cur_col);
  assign cur_bit  = (idx <= LAST_IDX) ? shape_q[idx] : 1'b0;
  assign dx_nx    = (dx == 3'd4) ? 3'd0 : dx + 3'd1;
  assign dy_nx    = (dx == 3'd4) ? dy + 3'd1 : dy;

`ifdef BOARD_VRAM_WRITER_COLLISION_CHECK_EN
  logic rd_v;
  logic coll;
  logic in_board;
  logic hit;

  assign in_board = (cur_row < BW5) && (cur_col < BW5);
  assign hit      = coll | (rd_v && (vram_q != '0));
`else
  logic unused_q;

  assign unused_q       = ^vram_q;
  assign vram_rdaddress = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cmd_ready      <= 1'b1;
      vram_wren      <= 1'b0;
      vram_wraddress <= '0;
      vram_data      <= '0;
      done           <= 1'b0;
      err            <= 2'b00;
      shape_q        <= '0;
      x_q            <= '0;
      y_q            <= '0;
      cell_q         <= '0;
      idx            <= '0;
      dx             <= '0;
      dy             <= '0;
      clr_cnt        <= '0;
`ifdef BOARD_VRAM_WRITER_COLLISION_CHECK_EN
      vram_rdaddress <= '0;
      rd_v           <= 1'b0;
      coll           <= 1'b0;
`endif
    end else begin
      vram_wren <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            shape_q   <= cmd_shape;
            x_q       <= cmd_x;
            y_q       <= cmd_y;
            cell_q    <= cmd_cell;
            idx       <= '0;
            dx        <= '0;
            dy        <= '0;
            clr_cnt   <= '0;
            err       <= 2'b00;
            cmd_ready <= 1'b0;
`ifdef BOARD_VRAM_WRITER_COLLISION_CHECK_EN
            rd_v      <= 1'b0;
            coll      <= 1'b0;
`endif
            if (cmd_op) begin
              state <= CLEAR;
            end else if (off_board) begin
              err   <= 2'b01;
              done  <= 1'b1;
              state <= DONE;
            end else begin
`ifdef BOARD_VRAM_WRITER_COLLISION_CHECK_EN
              state <= CHECK;
`else
              state <= PLACE;
`endif
            end
          end
        end
        CLEAR: begin
          vram_wren      <= 1'b1;
          vram_wraddress <= clr_cnt;
          vram_data      <= '0;
          if (clr_cnt == LAST_ADDR) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
`ifdef BOARD_VRAM_WRITER_COLLISION_CHECK_EN
        CHECK: begin
          // idx 0..24 issue reads; idx 25 drains the last read
          if (idx <= LAST_IDX) begin
            vram_rdaddress <= cur_addr;
            rd_v           <= cur_bit & in_board;
            coll           <= hit;
            idx            <= idx + 5'd1;
            dx             <= dx_nx;
            dy             <= dy_nx;
          end else begin
            rd_v <= 1'b0;
            coll <= hit;
            idx  <= '0;
            dx   <= '0;
            dy   <= '0;
            if (hit) begin
              err   <= 2'b10;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= PLACE;
            end
          end
        end
`endif
        PLACE: begin
          vram_wren      <= cur_bit;
          vram_wraddress <= cur_addr;
          vram_data      <= cell_q;
          idx            <= idx + 5'd1;
          dx             <= dx_nx;
          dy             <= dy_nx;
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_vram_writer.sv
// Bench for board_vram_writer: directed table, corner sequences, random
// commands checked against a cell-level reference board model.
module tb_board_vram_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [24:0] cmd_shape;
  logic [3:0]  cmd_x;
  logic [3:0]  cmd_y;
  logic [5:0]  cmd_cell;
  logic [7:0]  vram_wraddress;
  logic [5:0]  vram_data;
  logic        vram_wren;
  logic [7:0]  vram_rdaddress;
  logic [5:0]  vram_q;
  logic        done;
  logic [1:0]  err;

  always #5 clk = ~clk;

  board_vram_writer dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_shape(cmd_shape),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_cell(cmd_cell),
    .vram_wraddress(vram_wraddress),
    .vram_data(vram_data),
    .vram_wren(vram_wren),
    .vram_rdaddress(vram_rdaddress),
    .vram_q(vram_q),
    .done(done),
    .err(err)
  );

`ifdef BOARD_VRAM_WRITER_COLLISION_CHECK_EN
  localparam int LP = 52;
  localparam int COLL_ERR = 2;
  localparam int COLL_LAT = 27;
  localparam int COLL_NWR = 0;
`else
  localparam int LP = 26;
  localparam int COLL_ERR = 0;
  localparam int COLL_LAT = 26;
  localparam int COLL_NWR = 3;
`endif

  logic [5:0] mem [196];
  logic [5:0] ref_mem [196];
  int cyc = 0;
  int wlog_a[$];
  int wlog_d[$];
  int wlog_c[$];
  int done_q[$];
  int acc_q[$];
  int ea[$];
  int ed[$];
  int e_err;
  int e_lat;
  int got_lat;
  int got_err;
  int got_nwr;
  int n_run = 0;
  int n_fail = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    vram_q <= (vram_rdaddress < 8'd196) ? mem[vram_rdaddress] : 6'd0;
    if (rst_n) begin
      if (vram_wren) begin
        wlog_a.push_back(int'(vram_wraddress));
        wlog_d.push_back(int'(vram_data));
        wlog_c.push_back(cyc);
        if (vram_wraddress < 8'd196) mem[vram_wraddress] = vram_data;
      end
      if (done) done_q.push_back(cyc);
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc + 1);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: whole-command effect on the board, computed cell by cell.
  task automatic model(input bit op, input logic [24:0] sh, input int x,
                       input int y, input logic [5:0] c);
    bit off;
    bit hit;
    ea.delete();
    ed.delete();
    if (op) begin
      for (int a = 0; a < 196; a++) begin
        ea.push_back(a);
        ed.push_back(0);
        ref_mem[a] = 6'd0;
      end
      e_err = 0;
      e_lat = 197;
      return;
    end
    off = 0;
    hit = 0;
    for (int i = 0; i < 25; i++) begin
      if (sh[i]) begin
        if (x + i % 5 >= 14 || y + i / 5 >= 14) off = 1;
        else if (ref_mem[(y + i / 5) * 14 + x + i % 5] != 0) hit = 1;
      end
    end
    if (off) begin
      e_err = 1;
      e_lat = 1;
      return;
    end
`ifdef BOARD_VRAM_WRITER_COLLISION_CHECK_EN
    if (hit) begin
      e_err = 2;
      e_lat = 27;
      return;
    end
`endif
    e_err = 0;
    e_lat = LP;
    for (int i = 0; i < 25; i++) begin
      if (sh[i]) begin
        ea.push_back((y + i / 5) * 14 + x + i % 5);
        ed.push_back(int'(c));
        ref_mem[(y + i / 5) * 14 + x + i % 5] = c;
      end
    end
  endtask

  task automatic clear_logs();
    wlog_a.delete();
    wlog_d.delete();
    wlog_c.delete();
    done_q.delete();
    acc_q.delete();
  endtask

  task automatic drive(input bit op, input logic [24:0] sh, input int x,
                       input int y, input logic [5:0] c);
    cmd_op = op;
    cmd_shape = sh;
    cmd_x = 4'(x);
    cmd_y = 4'(y);
    cmd_cell = c;
  endtask

  task automatic wait_acc(input int n, output bit ok);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (acc_q.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_q.size() >= n) break;
    end
  endtask

  task automatic run_cmd(input string nm, input bit op, input logic [24:0] sh,
                         input int x, input int y, input logic [5:0] c);
    bit ok;
    int bad;
    model(op, sh, x, y, c);
    @(posedge clk);
    #1;
    clear_logs();
    drive(op, sh, x, y, c);
    cmd_valid = 1'b1;
    wait_acc(1, ok);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      chk({nm, " accept"}, 0, 1);
      return;
    end
    wait_done(1);
    repeat (3) @(negedge clk);
    got_nwr = wlog_a.size();
    got_err = int'(err);
    got_lat = (done_q.size() > 0) ? done_q[0] - acc_q[0] + 1 : -1;
    chk({nm, " lat"}, got_lat, e_lat);
    chk({nm, " err"}, got_err, e_err);
    chk({nm, " ndone"}, done_q.size(), 1);
    chk({nm, " nwr"}, got_nwr, ea.size());
    bad = 0;
    for (int j = 0; j < got_nwr && j < ea.size(); j++)
      if (wlog_a[j] != ea[j] || wlog_d[j] != ed[j]) bad++;
    chk({nm, " wrlist"}, bad, 0);
  endtask

  typedef struct {
    string       nm;
    bit          op;
    logic [24:0] sh;
    int          x;
    int          y;
    logic [5:0]  c;
    int          err;
    int          lat;
    int          nwr;
    int          a0;
  } vec_t;

  vec_t tbl [8];

  initial begin
    bit ok;
    int n1;
    int ea_all[$];
    int bad;
    logic [24:0] sh;

    tbl[0] = '{"clear", 1'b1, 25'h0, 0, 0, 6'h00, 0, 197, 196, 0};
    tbl[1] = '{"bar", 1'b0, 25'h0000007, 2, 3, 6'h20, 0, LP, 3, 44};
    tbl[2] = '{"off_x14", 1'b0, 25'h0000010, 10, 0, 6'h05, 1, 1, 0, -1};
    tbl[3] = '{"edge_x13", 1'b0, 25'h0000010, 9, 0, 6'h05, 0, LP, 1, 13};
    tbl[4] = '{"empty", 1'b0, 25'h0, 5, 5, 6'h11, 0, LP, 0, -1};
    tbl[5] = '{"full", 1'b0, 25'h1FFFFFF, 9, 9, 6'h03, 0, LP, 25, 135};
    tbl[6] = '{"off_y14", 1'b0, 25'h0100000, 0, 10, 6'h07, 1, 1, 0, -1};
    tbl[7] = '{"overlap", 1'b0, 25'h0000007, 2, 3, 6'h01,
               COLL_ERR, COLL_LAT, COLL_NWR, -1};

    for (int a = 0; a < 196; a++) begin
      mem[a] = 6'h3F;
      ref_mem[a] = 6'h3F;
    end
    vram_q = 6'd0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    drive(0, 25'h0, 0, 0, 6'h0);
    repeat (2) @(negedge clk);
    chk("rst ready", cmd_ready, 1);
    chk("rst wren", vram_wren, 0);
    chk("rst wraddr", vram_wraddress, 0);
    chk("rst data", vram_data, 0);
    chk("rst rdaddr", vram_rdaddress, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      run_cmd(tbl[t].nm, tbl[t].op, tbl[t].sh, tbl[t].x, tbl[t].y, tbl[t].c);
      chk({tbl[t].nm, " t_err"}, got_err, tbl[t].err);
      chk({tbl[t].nm, " t_lat"}, got_lat, tbl[t].lat);
      chk({tbl[t].nm, " t_nwr"}, got_nwr, tbl[t].nwr);
      if (tbl[t].a0 >= 0)
        chk({tbl[t].nm, " t_a0"}, (got_nwr > 0) ? wlog_a[0] : -1, tbl[t].a0);
    end

    // Reset in the middle of a board clear
    @(posedge clk);
    #1;
    clear_logs();
    drive(1, 25'h0, 0, 0, 6'h0);
    cmd_valid = 1'b1;
    wait_acc(1, ok);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (wlog_a.size() >= 51) break;
      @(negedge clk);
    end
    chk("mid_clear reached", (wlog_a.size() >= 51) ? 1 : 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort wren", vram_wren, 0);
    chk("abort done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (250) @(negedge clk);
    chk("abort no_done", done_q.size(), 0);
    chk("abort no_wr", wlog_a.size(), 0);
    chk("abort ready", cmd_ready, 1);
    run_cmd("resync_clear", 1'b1, 25'h0, 0, 0, 6'h0);

    // Back-to-back commands with cmd_valid held high
    model(0, 25'h7, 0, 0, 6'h09);
    ea_all = ea;
    n1 = ea.size();
    model(0, 25'h3, 5, 5, 6'h04);
    foreach (ea[j]) ea_all.push_back(ea[j]);
    @(posedge clk);
    #1;
    clear_logs();
    drive(0, 25'h7, 0, 0, 6'h09);
    cmd_valid = 1'b1;
    wait_acc(1, ok);
    @(posedge clk);
    #1;
    drive(0, 25'h3, 5, 5, 6'h04);
    wait_acc(2, ok);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("b2b accepted2", ok, 1);
    wait_done(2);
    repeat (3) @(negedge clk);
    chk("b2b ndone", done_q.size(), 2);
    if (ok && done_q.size() >= 1)
      chk("b2b acc_after_done", acc_q[1], done_q[0] + 2);
    chk("b2b nwr", wlog_a.size(), ea_all.size());
    bad = 0;
    for (int j = 0; j < wlog_a.size() && j < ea_all.size(); j++)
      if (wlog_a[j] != ea_all[j]) bad++;
    chk("b2b wrlist", bad, 0);
    if (ok && wlog_c.size() > n1) begin
      chk("b2b first_done", (wlog_c[n1 - 1] < acc_q[1]) ? 1 : 0, 1);
      chk("b2b second_after", (wlog_c[n1] > acc_q[1]) ? 1 : 0, 1);
    end

    // Random commands against the reference board
    for (int r = 0; r < 40; r++) begin
      sh = 25'($urandom);
      if ($urandom_range(0, 1) == 1) sh = sh & 25'($urandom) & 25'($urandom);
      run_cmd($sformatf("rnd%0d", r), ($urandom_range(0, 11) == 0),
              sh, $urandom_range(0, 15), $urandom_range(0, 15),
              6'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
